// File: rtl/wb_commit_stage_pkg.sv
// Shared writeback-stage definitions: default field widths, exception codes and
// the packed bus widths derived from them.
`timescale 1ns/1ps
package wb_commit_stage_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_RADDR_W = 5;
    localparam int WB_CSRN_W  = 14;
    localparam int WB_ECODE_W = 6;
    localparam int WB_CNT_W   = 64;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // pc, rf_wdata, csr_wmask, csr_wdata, badv + rf_we, csr_we, excp, ertn
    function automatic int mem_to_wb_wd(input int dw, input int aw, input int cw, input int ew);
        return 5 * dw + aw + cw + ew + 4;
    endfunction

    // valid, we, waddr, wdata
    function automatic int wb_to_id_wd(input int dw, input int aw);
        return 2 + aw + dw;
    endfunction

    localparam int MEM_TO_WB_WD = mem_to_wb_wd(WB_DATA_W, WB_RADDR_W, WB_CSRN_W, WB_ECODE_W);
    localparam int WB_TO_ID_WD  = wb_to_id_wd(WB_DATA_W, WB_RADDR_W);

endpackage

// File: rtl/wb_commit_stage_if.sv
// MEM -> WB handshake and instruction fields.
`timescale 1ns/1ps
interface wb_commit_stage_if
    import wb_commit_stage_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int RADDR_W = WB_RADDR_W,
    parameter int CSRN_W  = WB_CSRN_W,
    parameter int ECODE_W = WB_ECODE_W
);
    logic               mem_to_wb_valid;
    logic               wb_allowin;
    logic [DATA_W-1:0]  mem_pc;
    logic               mem_rf_we;
    logic [RADDR_W-1:0] mem_rf_waddr;
    logic [DATA_W-1:0]  mem_rf_wdata;
    logic               mem_csr_we;
    logic [CSRN_W-1:0]  mem_csr_num;
    logic [DATA_W-1:0]  mem_csr_wmask;
    logic [DATA_W-1:0]  mem_csr_wdata;
    logic               mem_excp;
    logic               mem_ertn;
    logic [ECODE_W-1:0] mem_ecode;
    logic [DATA_W-1:0]  mem_badv;

    modport master (
        output mem_to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
               mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wdata,
               mem_excp, mem_ertn, mem_ecode, mem_badv,
        input  wb_allowin
    );

    modport slave (
        input  mem_to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
               mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wdata,
               mem_excp, mem_ertn, mem_ecode, mem_badv,
        output wb_allowin
    );

endinterface

// File: rtl/wb_commit_stage_stage_reg.sv
// Generic one-entry pipeline stage register: valid bit with allowin/ready_go
// handshake and an unreset data payload.
`timescale 1ns/1ps
module wb_commit_stage_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         ready_go,
    input  logic         flush,
    output logic         allowin,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    assign allowin = ~out_valid | ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
        end else if (allowin) begin
            out_valid <= in_valid & ~flush;
        end
    end

    // Payload may be captured during a flush; valid=0 makes it don't-care.
    always_ff @(posedge clk) begin
        if (allowin && in_valid) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: commits regfile and CSR writes, exceptions and ertn,
// and drives the ID forwarding bus, debug trace and retired-instruction counter.
`timescale 1ns/1ps
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int RADDR_W = WB_RADDR_W,
    parameter int CSRN_W  = WB_CSRN_W,
    parameter int ECODE_W = WB_ECODE_W,
    parameter int CNT_W   = WB_CNT_W
) (
    input  logic               clk,
    input  logic               resetn,
    wb_commit_stage_if.slave   mem_bus,
    input  logic               wb_stall,
    input  logic [DATA_W-1:0]  csr_eentry,
    input  logic [DATA_W-1:0]  csr_era,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               fwd_valid,
    output logic               fwd_we,
    output logic               csr_we,
    output logic [CSRN_W-1:0]  csr_num,
    output logic [DATA_W-1:0]  csr_wmask,
    output logic [DATA_W-1:0]  csr_wdata,
    output logic               excp_commit,
    output logic               ertn_commit,
    output logic [ECODE_W-1:0] excp_ecode,
    output logic [DATA_W-1:0]  excp_pc,
    output logic [DATA_W-1:0]  excp_badv,
    output logic               wb_flush,
    output logic [DATA_W-1:0]  wb_flush_target,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [DATA_W-1:0]  debug_wb_pc,
    output logic [3:0]         debug_wb_rf_wen,
    output logic [RADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

    localparam int MW = mem_to_wb_wd(DATA_W, RADDR_W, CSRN_W, ECODE_W);

    logic [MW-1:0]      mem_data;
    logic [MW-1:0]      st_data;
    logic               wb_valid;
    logic               ready_go;
    logic               retire;

    logic [DATA_W-1:0]  st_pc;
    logic               st_rf_we;
    logic [RADDR_W-1:0] st_rf_waddr;
    logic [DATA_W-1:0]  st_rf_wdata;
    logic               st_csr_we;
    logic [CSRN_W-1:0]  st_csr_num;
    logic [DATA_W-1:0]  st_csr_wmask;
    logic [DATA_W-1:0]  st_csr_wdata;
    logic               st_excp;
    logic               st_ertn;
    logic [ECODE_W-1:0] st_ecode;
    logic [DATA_W-1:0]  st_badv;

    assign ready_go = ~wb_stall;

    assign mem_data = {mem_bus.mem_pc, mem_bus.mem_rf_we, mem_bus.mem_rf_waddr,
                       mem_bus.mem_rf_wdata, mem_bus.mem_csr_we, mem_bus.mem_csr_num,
                       mem_bus.mem_csr_wmask, mem_bus.mem_csr_wdata, mem_bus.mem_excp,
                       mem_bus.mem_ertn, mem_bus.mem_ecode, mem_bus.mem_badv};

    wb_commit_stage_stage_reg #(
        .W(MW)
    ) u_stage_reg (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (mem_bus.mem_to_wb_valid),
        .in_data  (mem_data),
        .ready_go (ready_go),
        .flush    (wb_flush),
        .allowin  (mem_bus.wb_allowin),
        .out_valid(wb_valid),
        .out_data (st_data)
    );

    assign {st_pc, st_rf_we, st_rf_waddr, st_rf_wdata, st_csr_we, st_csr_num,
            st_csr_wmask, st_csr_wdata, st_excp, st_ertn, st_ecode, st_badv} = st_data;

    assign retire = wb_valid & ready_go;

    // An excepting instruction suppresses all architectural writes.
    assign rf_we     = retire & st_rf_we & ~st_excp;
    assign rf_waddr  = st_rf_waddr;
    assign rf_wdata  = st_rf_wdata;

    assign csr_we    = retire & st_csr_we & ~st_excp;
    assign csr_num   = st_csr_num;
    assign csr_wmask = st_csr_wmask;
    assign csr_wdata = st_csr_wdata;

    assign excp_commit     = retire & st_excp;
    assign ertn_commit     = retire & st_ertn & ~st_excp;
    assign excp_ecode      = st_ecode;
    assign excp_pc         = st_pc;
    assign excp_badv       = st_badv;
    assign wb_flush        = excp_commit | ertn_commit;
    assign wb_flush_target = st_excp ? csr_eentry : csr_era;

    // Forwarding stays visible while stalled so ID can keep bypassing.
    assign fwd_valid = wb_valid;
    assign fwd_we    = wb_valid & st_rf_we & ~st_excp;

    assign debug_wb_pc       = st_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = st_rf_waddr;
    assign debug_wb_rf_wdata = st_rf_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: stimulus pushes expected commits,
// a monitor pops and compares whenever the stage presents a commit.
`timescale 1ns/1ps
module tb_wb_commit_stage;
    import wb_commit_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_we;
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] cdata;
        logic        excp;
        logic        ertn;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } instr_t;

    typedef struct {
        instr_t      i;
        logic        rf_we;
        logic        csr_we;
        logic        excp;
        logic        ertn;
        logic [31:0] target;
    } exp_t;

    localparam logic [31:0] EENTRY = 32'h1c00_8000;
    localparam logic [31:0] ERA    = 32'h1c00_0040;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_stall;
    logic [31:0] csr_eentry, csr_era;
    logic        rf_we, fwd_valid, fwd_we, csr_we, excp_commit, ertn_commit, wb_flush;
    logic [4:0]  rf_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, csr_wmask, csr_wdata, excp_pc, excp_badv, wb_flush_target;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [13:0] csr_num;
    logic [5:0]  excp_ecode;
    logic [3:0]  retire_cnt;
    logic [3:0]  debug_wb_rf_wen;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    wb_commit_stage_if #(.DATA_W(32), .RADDR_W(5), .CSRN_W(14), .ECODE_W(6)) mem_bus ();

    wb_commit_stage #(
        .DATA_W(32), .RADDR_W(5), .CSRN_W(14), .ECODE_W(6), .CNT_W(4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_bus          (mem_bus),
        .wb_stall         (wb_stall),
        .csr_eentry       (csr_eentry),
        .csr_era          (csr_era),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .fwd_valid        (fwd_valid),
        .fwd_we           (fwd_we),
        .csr_we           (csr_we),
        .csr_num          (csr_num),
        .csr_wmask        (csr_wmask),
        .csr_wdata        (csr_wdata),
        .excp_commit      (excp_commit),
        .ertn_commit      (ertn_commit),
        .excp_ecode       (excp_ecode),
        .excp_pc          (excp_pc),
        .excp_badv        (excp_badv),
        .wb_flush         (wb_flush),
        .wb_flush_target  (wb_flush_target),
        .retire_cnt       (retire_cnt),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic rf, input logic [4:0] wa,
                                  input logic [31:0] wd, input logic cw, input logic [13:0] num,
                                  input logic [31:0] cd, input logic ex, input logic er,
                                  input logic [5:0] ec, input logic [31:0] bv);
        instr_t t;
        t.pc = pc; t.rf_we = rf; t.waddr = wa; t.wdata = wd;
        t.csr_we = cw; t.num = num; t.mask = 32'hFFFF_FFFF; t.cdata = cd;
        t.excp = ex; t.ertn = er; t.ecode = ec; t.badv = bv;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        mem_bus.mem_to_wb_valid = 1'b1;
        mem_bus.mem_pc        = t.pc;
        mem_bus.mem_rf_we     = t.rf_we;
        mem_bus.mem_rf_waddr  = t.waddr;
        mem_bus.mem_rf_wdata  = t.wdata;
        mem_bus.mem_csr_we    = t.csr_we;
        mem_bus.mem_csr_num   = t.num;
        mem_bus.mem_csr_wmask = t.mask;
        mem_bus.mem_csr_wdata = t.cdata;
        mem_bus.mem_excp      = t.excp;
        mem_bus.mem_ertn      = t.ertn;
        mem_bus.mem_ecode     = t.ecode;
        mem_bus.mem_badv      = t.badv;
    endtask

    // Offer an instruction, record its expected commit, advance one cycle.
    task automatic send(input instr_t t, input logic e_rf, input logic e_csr,
                        input logic e_ex, input logic e_er, input logic [31:0] tgt);
        exp_t e;
        e.i = t; e.rf_we = e_rf; e.csr_we = e_csr; e.excp = e_ex; e.ertn = e_er; e.target = tgt;
        drive(t);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        mem_bus.mem_to_wb_valid = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: samples just before each rising edge.
    initial begin : monitor
        logic [3:0] exp_cnt;
        exp_t       e;
        exp_cnt = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!resetn) begin
                exp_cnt = '0;
            end else if (rf_we || csr_we || excp_commit || ertn_commit || wb_flush ||
                         (debug_wb_rf_wen != 4'h0)) begin
                if (sb.size() == 0) begin
                    check("unexpected_commit", {31'd0, rf_we, 1'b0, csr_we, excp_commit, ertn_commit}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rf_we", rf_we, e.rf_we);
                    check("trace_wen", debug_wb_rf_wen, {4{e.rf_we}});
                    if (e.rf_we) begin
                        check("rf_waddr", rf_waddr, e.i.waddr);
                        check("rf_wdata", rf_wdata, e.i.wdata);
                        check("trace_pc", debug_wb_pc, e.i.pc);
                        check("trace_wnum", debug_wb_rf_wnum, e.i.waddr);
                        check("trace_wdata", debug_wb_rf_wdata, e.i.wdata);
                    end
                    check("csr_we", csr_we, e.csr_we);
                    if (e.csr_we) begin
                        check("csr_num", csr_num, e.i.num);
                        check("csr_wmask", csr_wmask, e.i.mask);
                        check("csr_wdata", csr_wdata, e.i.cdata);
                    end
                    check("excp_commit", excp_commit, e.excp);
                    check("ertn_commit", ertn_commit, e.ertn);
                    check("wb_flush", wb_flush, e.excp | e.ertn);
                    if (e.excp | e.ertn) check("flush_target", wb_flush_target, e.target);
                    if (e.excp) begin
                        check("excp_ecode", excp_ecode, e.i.ecode);
                        check("excp_pc", excp_pc, e.i.pc);
                        check("excp_badv", excp_badv, e.i.badv);
                    end
                    check("retire_cnt_mon", retire_cnt, exp_cnt);
                end
                exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        resetn = 1'b0;
        wb_stall = 1'b0;
        csr_eentry = EENTRY;
        csr_era = ERA;
        mem_bus.mem_to_wb_valid = 1'b0;
        drive(mk(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0));
        mem_bus.mem_to_wb_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_allowin", mem_bus.wb_allowin, 1'b1);
        check("rst_retire_cnt", retire_cnt, 4'd0);
        check("rst_pulses", {rf_we, csr_we, excp_commit, ertn_commit, wb_flush}, 5'b0);
        resetn = 1'b1;
        @(negedge clk);

        // back-to-back adds r1..r3
        send(mk(32'h1c00_0000, 1'b1, 5'd1, 32'h0000_0011, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        send(mk(32'h1c00_0004, 1'b1, 5'd2, 32'h0000_0022, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        send(mk(32'h1c00_0008, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        idle();
        #1 check("retire_cnt_3", retire_cnt, 4'd3);

        // stall held for 3 cycles, next instruction waits at the input
        wb_stall = 1'b1;
        send(mk(32'h1c00_0010, 1'b1, 5'd5, 32'h0000_0055, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        #1;
        check("stall_allowin_1", mem_bus.wb_allowin, 1'b0);
        check("stall_fwd_we_1", fwd_we, 1'b1);
        check("stall_fwd_valid", fwd_valid, 1'b1);
        send(mk(32'h1c00_0014, 1'b1, 5'd6, 32'h0000_0066, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        #1;
        check("stall_allowin_2", mem_bus.wb_allowin, 1'b0);
        check("stall_fwd_we_2", fwd_we, 1'b1);
        check("stall_no_rf_we", rf_we, 1'b0);
        @(negedge clk);
        #1 check("stall_allowin_3", mem_bus.wb_allowin, 1'b0);
        wb_stall = 1'b0;
        #1 check("release_allowin", mem_bus.wb_allowin, 1'b1);
        @(negedge clk);
        idle();
        #1 check("retire_cnt_5", retire_cnt, 4'd5);

        // exception; offer in the flush cycle must be dropped
        send(mk(32'h1c00_0020, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 14'h0C, 32'hDEAD_BEEF, 1'b1, 1'b0, ECODE_SYS, 32'h0000_1234), 0, 0, 1, 0, EENTRY);
        drive(mk(32'h1c00_0024, 1'b1, 5'd8, 32'h0000_0088, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0));
        #1 check("excp_flush_now", wb_flush, 1'b1);
        @(negedge clk);
        #1;
        check("flush_drop_valid", fwd_valid, 1'b0);
        check("flush_one_cycle", wb_flush, 1'b0);
        idle();

        // ertn
        send(mk(32'h1c00_0030, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, 6'h0, 32'h0), 0, 0, 0, 1, ERA);
        idle();
        #1 check("ertn_flush_cleared", wb_flush, 1'b0);

        // excp and ertn together: exception wins
        send(mk(32'h1c00_0034, 1'b0, 5'd0, 32'h0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, ECODE_BRK, 32'h0000_5678), 0, 0, 1, 0, EENTRY);
        idle();

        // csrwr writes CSR and the old value to rd
        send(mk(32'h1c00_0038, 1'b1, 5'd4, 32'h0000_00AA, 1'b1, 14'h0C, 32'h1234_5678, 1'b0, 1'b0, 6'h0, 32'h0), 1, 1, 0, 0, 32'h0);
        idle();
        #1 check("retire_cnt_9", retire_cnt, 4'd9);

        // seven more retires wrap a 4-bit counter to zero
        for (int k = 0; k < 7; k++) begin
            send(mk(32'h1c00_0100 + 32'(k * 4), 1'b1, 5'(10 + k), 32'h100 + 32'(k), 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        end
        idle();
        #1 check("retire_cnt_wrap", retire_cnt, 4'd0);
        send(mk(32'h1c00_0200, 1'b1, 5'd31, 32'h0000_0F0F, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0), 1, 0, 0, 0, 32'h0);
        idle();
        #1 check("retire_cnt_after_wrap", retire_cnt, 4'd1);

        // reset while an instruction is stalled: it must never commit
        wb_stall = 1'b1;
        drive(mk(32'h1c00_0300, 1'b1, 5'd9, 32'h0000_0999, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 6'h0, 32'h0));
        @(negedge clk);
        mem_bus.mem_to_wb_valid = 1'b0;
        #1 check("pre_reset_held", fwd_valid, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check("reset_discard", fwd_valid, 1'b0);
        check("reset_cnt", retire_cnt, 4'd0);
        resetn = 1'b1;
        wb_stall = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
